// File: rtl/huffman_mcu_scheduler_pkg.sv
// huffman_mcu_scheduler_pkg: symbol type, state encoding and component/table constants
package huffman_mcu_scheduler_pkg;
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] vli;
  } tempCode_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RSTM} schedState_t;
  typedef logic [1:0] compIdx_t;
  localparam logic TBL_LUMA = 1'b0;
  localparam logic TBL_CHROMA = 1'b1;
  localparam compIdx_t COMP_Y = 2'd0;
  localparam compIdx_t COMP_CB = 2'd1;
  localparam compIdx_t COMP_CR = 2'd2;
  function automatic compIdx_t slot_comp(input int slot, input int y_blocks);
    return slot < y_blocks ? COMP_Y : slot == y_blocks ? COMP_CB : COMP_CR;
  endfunction
endpackage

// File: rtl/huffman_mcu_scheduler_if.sv
// huffman_mcu_scheduler_if: per-component symbol inputs and the shared encoder output channel
interface huffman_mcu_scheduler_if import huffman_mcu_scheduler_pkg::*; #(
  parameter int NUM_COMP = 3
);
  tempCode_t [NUM_COMP-1:0] in_code;
  logic [NUM_COMP-1:0] in_ready;
  tempCode_t out_code;
  logic out_ready;
  logic tbl_sel;
  compIdx_t comp_idx;
  modport master (output in_code, out_ready, input in_ready, out_code, tbl_sel, comp_idx);
  modport slave (input in_code, out_ready, output in_ready, out_code, tbl_sel, comp_idx);
endinterface

// File: rtl/huffman_mcu_scheduler_out_reg.sv
// huffman_sched_out_reg: single-entry valid/ready register for symbol, table select and component
module huffman_sched_out_reg import huffman_mcu_scheduler_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  tempCode_t code_d,
  input  logic      tbl_d,
  input  compIdx_t  comp_d,
  input  logic      ready,
  output tempCode_t code,
  output logic      tbl,
  output compIdx_t  comp,
  output logic      accept
);
  assign accept = !code.valid || ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      code <= '0;
      tbl <= 1'b0;
      comp <= '0;
    end else if (load) begin
      code <= code_d;
      tbl <= tbl_d;
      comp <= comp_d;
    end else if (ready) begin
      code.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/huffman_mcu_scheduler.sv
// huffman_mcu_scheduler: interleaves Y/Cb/Cr symbol streams into one Huffman encoder in MCU order.
// Optional restart-marker handshake is built when HUFF_SCHED_RESTART_EN is defined.
module huffman_mcu_scheduler import huffman_mcu_scheduler_pkg::*; #(
  parameter int NUM_COMP     = 3,
  parameter int Y_BLOCKS     = 4,
  parameter int MCU_W        = 16,
  parameter int RST_INTERVAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MCU_W-1:0] num_mcu,
  output logic             busy,
  output logic             frame_done,
`ifdef HUFF_SCHED_RESTART_EN
  output logic             rst_req,
  input  logic             rst_ack,
  output logic [2:0]       rst_idx,
`endif
  huffman_mcu_scheduler_if.slave bus
);
  localparam int SW = $clog2(Y_BLOCKS + 2);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  logic [1:0] state;
  logic [SW-1:0] slot;
  logic [MCU_W-1:0] mcu_cnt, mcu_total;
  logic [NUM_COMP-1:0] ready;
  compIdx_t sel, out_comp;
  tempCode_t cur, out_code;
  logic reg_free, accept, xfer, blk_end, last_slot, last_mcu, out_tbl;
  assign sel = slot_comp(int'(slot), Y_BLOCKS);
  assign cur = bus.in_code[sel];
  assign accept = state == S_RUN && reg_free;
  assign xfer = cur.valid && accept;
  assign blk_end = xfer && cur.done;
  assign last_slot = slot == SW'(Y_BLOCKS + 1);
  assign last_mcu = mcu_cnt == mcu_total - 1'b1;
  // only the scheduled channel sees ready; the others are held off without losing data
  always_comb begin
    ready = '0;
    ready[sel] = accept;
  end
  assign bus.in_ready = ready;
  assign bus.out_code = out_code;
  assign bus.tbl_sel = out_tbl;
  assign bus.comp_idx = out_comp;
  huffman_sched_out_reg u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (xfer),
    .code_d (cur),
    .tbl_d  (sel == COMP_Y ? TBL_LUMA : TBL_CHROMA),
    .comp_d (sel),
    .ready  (bus.out_ready),
    .code   (out_code),
    .tbl    (out_tbl),
    .comp   (out_comp),
    .accept (reg_free)
  );
`ifdef HUFF_SCHED_RESTART_EN
  localparam logic [1:0] S_RSTM = RSTM;
  localparam int RW = RST_INTERVAL > 1 ? $clog2(RST_INTERVAL) : 1;
  logic [RW-1:0] rst_cnt;
  logic rst_hit;
  assign rst_hit = rst_cnt == RW'(RST_INTERVAL - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^RST_INTERVAL;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      slot <= '0;
      mcu_cnt <= '0;
      mcu_total <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
`ifdef HUFF_SCHED_RESTART_EN
      rst_cnt <= '0;
      rst_req <= 1'b0;
      rst_idx <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start && num_mcu != '0) begin
          state <= S_RUN;
          slot <= '0;
          mcu_cnt <= '0;
          mcu_total <= num_mcu;
          busy <= 1'b1;
`ifdef HUFF_SCHED_RESTART_EN
          rst_cnt <= '0;
          rst_idx <= '0;
`endif
        end
        S_RUN: if (blk_end) begin
          slot <= last_slot ? '0 : slot + 1'b1;
          if (last_slot) begin
            mcu_cnt <= mcu_cnt + 1'b1;
`ifdef HUFF_SCHED_RESTART_EN
            rst_cnt <= last_mcu || rst_hit ? '0 : rst_cnt + 1'b1;
            state <= last_mcu ? S_DRAIN : rst_hit ? S_RSTM : S_RUN;
`else
            state <= last_mcu ? S_DRAIN : S_RUN;
`endif
          end
        end
        // frame ends only once the encoder has taken the final symbol
        S_DRAIN: if (!out_code.valid) begin
          state <= S_IDLE;
          busy <= 1'b0;
          frame_done <= 1'b1;
        end
`ifdef HUFF_SCHED_RESTART_EN
        S_RSTM: if (rst_req && rst_ack) begin
          rst_req <= 1'b0;
          rst_idx <= rst_idx + 1'b1;
          state <= S_RUN;
        end else if (!out_code.valid) begin
          rst_req <= 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// tb_huffman_mcu_scheduler: randomized frames checked against a queue-based MCU-order model
module tb_huffman_mcu_scheduler;
  import huffman_mcu_scheduler_pkg::*;
`ifdef HUFF_SCHED_RESTART_EN
  localparam int RI = 2;
`else
  localparam int RI = 8;
`endif
  localparam int YB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] num_mcu = '0;
  logic busy, frame_done;
`ifdef HUFF_SCHED_RESTART_EN
  logic rst_req;
  logic rst_ack = 1'b0;
  logic [2:0] rst_idx;
`endif
  int errors = 0;
  int checks = 0;
  tempCode_t chq [3][$];
  tempCode_t expq [$];
  int expcomp [$];
  bit exprst [$];

  huffman_mcu_scheduler_if #(.NUM_COMP(3)) bus ();

  huffman_mcu_scheduler #(.NUM_COMP(3), .Y_BLOCKS(YB), .MCU_W(16), .RST_INTERVAL(RI)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_mcu    (num_mcu),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef HUFF_SCHED_RESTART_EN
    .rst_req    (rst_req),
    .rst_ack    (rst_ack),
    .rst_idx    (rst_idx),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic tempCode_t rand_sym(input bit done);
    tempCode_t s;
    s.valid = 1'b1;
    s.done = done;
    s.dc = 1'($urandom_range(1));
    s.run = 4'($urandom_range(15));
    s.size = 4'($urandom_range(15));
    s.vli = 11'($urandom_range(2047));
    return s;
  endfunction

  // expected encoder order: per MCU, YB luma blocks then one Cb and one Cr block
  task automatic build_frame(input int n, input int lo, input int hi, input bit mark);
    for (int c = 0; c < 3; c++) chq[c].delete();
    expq.delete();
    expcomp.delete();
    exprst.delete();
    for (int m = 0; m < n; m++) begin
      for (int s = 0; s < YB + 2; s++) begin
        int comp = s < YB ? 0 : s - YB + 1;
        int len = $urandom_range(hi, lo);
        for (int k = 0; k < len; k++) begin
          tempCode_t sym = rand_sym(k == len - 1);
          if (mark && comp == 1 && m == 0 && k == 0) sym.vli = 11'h1AB;
          chq[comp].push_back(sym);
          expq.push_back(sym);
          expcomp.push_back(comp);
          exprst.push_back(k == len - 1 && s == YB + 1 && (m + 1) % RI == 0 && m + 1 < n);
        end
      end
    end
  endtask

  task automatic run_frame(input int n, input int lo, input int hi, input int pv, input int pr,
                           input bit stall5, input bit b2b, input int abort_at, input bit mark);
    int ptr [3];
    int in_idx = 0, out_idx = 0, total, done_at = -1, first_hs = -1, last_hs = -1, stall_left = 0;
    int acks = 0, ack_wait = -1;
    bit occ = 0, stalled = 0, prev_hold = 0, rstm = 0, fin = 0, ordy;
    tempCode_t prev_code;
    tempCode_t ic [3];
    for (int c = 0; c < 3; c++) ptr[c] = 0;
    build_frame(n, lo, hi, mark);
    total = expq.size();
    @(negedge clk);
    start = 1'b1;
    num_mcu = 16'(n);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      int ec;
      bit can, occ_n;
      @(negedge clk);
      if (abort_at >= 0 && in_idx == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_code.valid !== 1'b0 || bus.in_ready !== 3'b000 || busy !== 1'b0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset: got valid=%b in_ready=%b busy=%b fd=%b want 0 000 0 0",
                   bus.out_code.valid, bus.in_ready, busy, frame_done);
        end
        rst = 1'b0;
        return;
      end
      for (int c = 0; c < 3; c++) begin
        if (ptr[c] < chq[c].size() && $urandom_range(99) < pv) ic[c] = chq[c][ptr[c]];
        else begin
          ic[c] = rand_sym(1'b0);
          ic[c].valid = 1'b0;
        end
        bus.in_code[c] = ic[c];
      end
      ordy = stall_left > 0 ? 1'b0 : 1'($urandom_range(99) < pr);
      if (stall_left > 0) stall_left--;
      bus.out_ready = ordy;
      start = in_idx > 0 && in_idx < total && $urandom_range(15) == 0;
      num_mcu = 16'($urandom_range(3, 1));
`ifdef HUFF_SCHED_RESTART_EN
      if (rst_req) begin
        if (ack_wait < 0) ack_wait = 3;
        rst_ack = ack_wait == 0;
        if (ack_wait > 0) ack_wait--;
      end else begin
        ack_wait = -1;
        rst_ack = 1'b0;
      end
`endif
      #1;
      ec = in_idx < total ? expcomp[in_idx] : 0;
      can = in_idx < total && !rstm && (!occ || ordy);
      for (int c = 0; c < 3; c++) begin
        bit e = can && c == ec;
        checks++;
        if (bus.in_ready[c] !== e) begin
          errors++;
          $display("FAIL in_ready[%0d] cyc %0d: got %b want %b", c, cyc, bus.in_ready[c], e);
        end
      end
      checks++;
      if (bus.out_code.valid !== occ) begin
        errors++;
        $display("FAIL out_valid cyc %0d: got %b want %b", cyc, bus.out_code.valid, occ);
      end
      checks++;
      if (busy !== !(done_at >= 0 && cyc - done_at >= 2) || frame_done !== (done_at >= 0 && cyc - done_at == 2)) begin
        errors++;
        $display("FAIL busy_done cyc %0d: got busy=%b fd=%b want busy=%b fd=%b", cyc, busy, frame_done,
                 !(done_at >= 0 && cyc - done_at >= 2), done_at >= 0 && cyc - done_at == 2);
      end
      if (prev_hold) begin
        checks++;
        if (bus.out_code !== prev_code) begin
          errors++;
          $display("FAIL hold cyc %0d: got %h want %h", cyc, bus.out_code, prev_code);
        end
      end
`ifdef HUFF_SCHED_RESTART_EN
      if (rst_req) begin
        checks++;
        if (!rstm || occ || rst_idx !== 3'(acks)) begin
          errors++;
          $display("FAIL rst_req cyc %0d: got rst_idx=%0d rstm=%b occ=%b want rst_idx=%0d rstm=1 occ=0",
                   cyc, rst_idx, rstm, occ, acks % 8);
        end
        if (rst_ack) begin
          acks++;
          rstm = 0;
        end
      end
`endif
      if (occ && ordy) begin
        checks++;
        if (bus.out_code !== expq[out_idx] || bus.comp_idx !== 2'(expcomp[out_idx]) ||
            bus.tbl_sel !== (expcomp[out_idx] != 0)) begin
          errors++;
          $display("FAIL sym %0d: got code=%h tbl=%b comp=%0d want code=%h tbl=%b comp=%0d", out_idx,
                   bus.out_code, bus.tbl_sel, bus.comp_idx, expq[out_idx], expcomp[out_idx] != 0, expcomp[out_idx]);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        out_idx++;
        if (out_idx == total) done_at = cyc;
      end
      if (can && ic[ec].valid) begin
        ptr[ec]++;
        if (exprst[in_idx]) rstm = 1;
        in_idx++;
        occ_n = 1;
      end else occ_n = occ && !ordy;
      prev_hold = occ && !ordy;
      prev_code = bus.out_code;
      occ = occ_n;
      if (stall5 && !stalled && out_idx == 6) begin
        stall_left = 5;
        stalled = 1;
      end
      if (done_at >= 0 && cyc - done_at == 3) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
`ifdef HUFF_SCHED_RESTART_EN
    rst_ack = 1'b0;
    checks++;
    if (acks != (n - 1) / RI) begin
      errors++;
      $display("FAIL restart_count: got %0d want %0d", acks, (n - 1) / RI);
    end
`endif
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: got out=%0d in=%0d want %0d symbols", out_idx, in_idx, total);
    end
`ifndef HUFF_SCHED_RESTART_EN
    if (b2b) begin
      checks++;
      if (last_hs - first_hs != total - 1) begin
        errors++;
        $display("FAIL b2b_span: got %0d cycles want %0d", last_hs - first_hs + 1, total);
      end
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    num_mcu = 16'd5;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) bus.in_code[c] = rand_sym(1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_code !== '0 || bus.in_ready !== 3'b000 || busy !== 1'b0 || frame_done !== 1'b0 ||
        bus.tbl_sel !== 1'b0 || bus.comp_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset: got code=%h rdy=%b busy=%b fd=%b tbl=%b comp=%0d want all 0",
               bus.out_code, bus.in_ready, busy, frame_done, bus.tbl_sel, bus.comp_idx);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b rdy=%b want 0 000", busy, bus.in_ready);
    end
  endtask

  task automatic test_zero_start();
    start = 1'b1;
    num_mcu = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 3'b000 || bus.out_code.valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_start: got busy=%b rdy=%b valid=%b want 0 000 0", busy, bus.in_ready, bus.out_code.valid);
    end
  endtask

  task automatic test_basic();
    run_frame(1, 3, 3, 100, 100, 0, 0, -1, 0);
  endtask

  task automatic test_holdoff();
    run_frame(1, 2, 4, 100, 100, 0, 0, -1, 1);
  endtask

  task automatic test_stall();
    run_frame(2, 3, 5, 100, 100, 1, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(3, 1, 1, 100, 100, 0, 1, -1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_frame($urandom_range(4, 1), 1, 6, 60, 70, 0, 0, -1, 0);
  endtask

  task automatic test_mid_reset();
    run_frame(3, 1, 1, 100, 100, 0, 0, 2 * (YB + 2) + 3, 0);
    run_frame(2, 1, 3, 80, 80, 0, 0, -1, 0);
  endtask

`ifdef HUFF_SCHED_RESTART_EN
  task automatic test_restart();
    run_frame(5, 1, 3, 90, 90, 0, 0, -1, 0);
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    bus.in_code = '0;
    test_reset();
    test_zero_start();
    test_basic();
    test_holdoff();
    test_stall();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef HUFF_SCHED_RESTART_EN
    test_restart();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/huffman_mcu_scheduler.md
Name: huffman_mcu_scheduler

Overview:
Sequences per-component coefficient-symbol streams (Y, Cb, Cr) into the single shared Huffman encoder in JPEG interleaved MCU order.
- Grants one component at a time. Switches component on the end-of-block beat (`done`=1).
- Tags each symbol with the luma/chroma table select.
- Counts MCUs per frame.
- Sits between the run-length/VLI stage and the Huffman encoder. Output is registered.

Parameters:
- NUM_COMP, 3: number of component input channels; fixed order Y=0, Cb=1, Cr=2.
- Y_BLOCKS, 4: luma blocks per MCU. 4 = 4:2:0, 2 = 4:2:2, 1 = 4:4:4.
- MCU_W, 16: width of the MCU counter and of `num_mcu`.
- RST_INTERVAL, 8: MCUs between restart markers; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame
- num_mcu  in  MCU_W  MCUs per frame; sampled on an accepted `start`
- in_code  in  NUM_COMP x tempCode_t  per-component symbol stream; `.valid` qualifies; `.done` marks the block's last symbol
- in_ready  out  NUM_COMP  per-channel accept
- out_code  out  tempCode_t  symbol to the encoder (registered)
- out_ready  in  1  encoder accept
- tbl_sel  out  1  0 = luma tables, 1 = chroma tables; registered alongside `out_code`
- comp_idx  out  2  component of the current `out_code`
- busy  out  1  high from accepted `start` until `frame_done`
- frame_done  out  1  one-cycle pulse when the frame is fully drained

Behaviour:
- Reset: all outputs 0, including `out_code.valid`, `in_ready` and `frame_done`. State IDLE; slot=0; mcu_cnt=0.
- States:
  - IDLE
  - RUN
  - DRAIN
  - RSTM (exists only with the optional feature)
- IDLE → RUN: on `start`=1 with `num_mcu` != 0. `start` with `num_mcu`=0 is ignored. `start` outside IDLE is ignored.
- Slot schedule per MCU: slots 0..Y_BLOCKS-1 select comp 0; slot Y_BLOCKS selects comp 1; slot Y_BLOCKS+1 selects comp 2.
- Handshake:
  - `accept` = state RUN && (!out_code.valid || out_ready).
  - `in_ready[sel]` = accept; every other `in_ready` bit is 0.
  - A beat transfers when `in_code[sel].valid` && `in_ready[sel]`.
- Output register:
  - On transfer, `out_code`/`tbl_sel`/`comp_idx` load next edge. Latency 1 cycle.
  - `out_code` is held stable while valid && !out_ready.
  - If out_ready && !transfer, `out_code.valid` clears.
  - Full throughput: one symbol per cycle.
- Slot advance: a transferred beat with `.done`=1 advances slot next cycle. The last slot wraps to 0 and increments mcu_cnt.
- Frame end: the `done` beat of the last slot with mcu_cnt == num_mcu-1 → DRAIN.
  - DRAIN waits for `out_code.valid`=0 (encoder consumed it).
  - Then pulses `frame_done` for 1 cycle, clears `busy`, returns to IDLE.
- A `.done` beat and an out_ready drain can occur in the same cycle; both take effect.
- `.valid` on non-selected channels is ignored; those channels are held off and no data is lost.
- `rst` mid-frame: immediate return to reset values. Any in-flight `out_code` is discarded.

Optional Feature:
- Macro: HUFF_SCHED_RESTART_EN.
- Defined: adds ports `rst_req` (out, 1), `rst_ack` (in, 1), `rst_idx` (out, 3).
  - After every RST_INTERVAL completed MCUs that are not the frame's last, enter RSTM.
  - RSTM waits for the output register to empty, then holds `rst_req`=1 with `rst_idx` stable until `rst_ack`=1.
  - On ack: `rst_idx` increments modulo 8; return to RUN at slot 0.
  - The restart counter and `rst_idx` clear on `start`.
- Undefined: ports, counter and RSTM are absent. MCUs flow back-to-back.

Decomposition:
- Shared package additions:
  - schedState_t enum {IDLE, RUN, DRAIN, RSTM}
  - localparams TBL_LUMA=0, TBL_CHROMA=1, COMP_Y=0, COMP_CB=1, COMP_CR=2
  - compIdx_t (2 bits)
- One natural sub-module: huffman_sched_out_reg.
  - Single-entry valid/ready pipeline register carrying {tempCode_t, tbl_sel, comp_idx}.
  - Exports its `accept` term.

Test Plan:
- Y_BLOCKS=4, num_mcu=1; each channel sends 3 symbols with done on the 3rd → 18 outputs in order Y,Y,Y,Y,Cb,Cr; `tbl_sel` 0 for the first 12, 1 for the last 6; `frame_done` exactly 1 cycle after the last `out_code` handshake.
- Cb presents valid=1 with symbol vli=9'h1AB while a Y block is active → `in_ready[1]`=0 until the 4th Y done beat; then vli=9'h1AB appears with `comp_idx`=1.
- `out_ready` held 0 for 5 cycles mid-block → `out_code` stable; `in_ready[sel]`=0 while output full; no symbol lost or duplicated; throughput returns to 1/cycle after release.
- num_mcu=3, all blocks single-symbol (done=1) with `out_ready`=1 → 18 outputs in 18 consecutive cycles; `busy` high throughout; `frame_done` then `busy`=0.
- `rst` asserted during MCU 2 slot 3 → next cycle `out_code.valid`=0, `in_ready`=0, `busy`=0; a fresh `start` restarts at slot 0, MCU 0.
- HUFF_SCHED_RESTART_EN with RST_INTERVAL=2, num_mcu=5 → `rst_req` after MCUs 2 and 4 only, with `rst_idx`=0 then 1; no symbols are granted while `rst_req`=1; `rst_ack` delayed 3 cycles is honoured.
